spi_slave_io: RTL



---
 rtl/spi_slave_io.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_io.sv
// spi_slave_io -- 8-bit SPI slave engine running entirely in the clk domain.
//
// The SPI pins are oversampled through 2-flop synchronizers. Edges are
// detected on the synchronized copies. The first byte of a transaction is a
// command byte ([7:6] cmd, [5:0] addr). The bytes that follow are written to
// a register file or read from it, one byte per register, with the address
// auto-incrementing and wrapping at 2**AW. Reads are prefetched so that the
// next byte is ready in the tx register before its first bit is shifted out.
//
// Ports:
//   clk        core clock
//   nreset     synchronous active-low reset
//   en         block enable; 0 holds the engine in IDLE and ignores ss
//   cpol/cpha  SPI mode; lsbfirst selects the bit order on mosi and miso
//   sclk/mosi/ss  SPI pins from the master (asynchronous to clk)
//   miso       slave data out, 0 whenever not selected
//   spi_write  one-cycle write strobe with spi_addr / spi_wdata
//   spi_read   one-cycle read request with spi_addr; spi_rdata valid next cycle
//   spi_state  0 IDLE, 1 CMD, 2 WRITE, 3 READ, 4 IGNORE
module spi_slave_io #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          lsbfirst,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          ss,
  output logic          miso,
  output logic          spi_write,
  output logic          spi_read,
  output logic [AW-1:0] spi_addr,
  output logic [7:0]    spi_wdata,
  input  logic [7:0]    spi_rdata,
  output logic [2:0]    spi_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_WRITE  = 3'd2,
    S_READ   = 3'd3,
    S_IGNORE = 3'd4
  } state_t;

  state_t state, state_next;

  // Pin synchronizers and edge-detect history.
  logic [1:0] sclk_pipe, mosi_pipe, ss_pipe;
  logic       sclk_d, ss_d;
  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_rise, sclk_fall, ss_fall;

  // Transfer datapath.
  logic          xfer_active, sample_edge, shift_edge, byte_done;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sr, rx_next;
  logic [7:0]    tx_sr, tx_hold, tx_load, tx_shifted;
  logic          tx_bit;
  logic [AW-1:0] addr;
  logic          prefetch, rd_capture;
  logic          cmd_done, rd_first, wr_fire, rd_next;

  // The synchronizers are reset to the idle pin levels (sclk at cpol, ss
  // high) so that releasing reset never manufactures an edge by itself.
  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sclk_pipe <= {cpol, cpol};
      sclk_d    <= cpol;
      mosi_pipe <= 2'b00;
      ss_pipe   <= 2'b11;
      ss_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[0], sclk};
      sclk_d    <= sclk_pipe[1];
      mosi_pipe <= {mosi_pipe[0], mosi};
      ss_pipe   <= {ss_pipe[0], ss};
      ss_d      <= ss_pipe[1];
    end
  end

  assign sclk_s    = sclk_pipe[1];
  assign mosi_s    = mosi_pipe[1];
  assign ss_s      = ss_pipe[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;

  // Sample on the rising edge when cpol==cpha (modes 0 and 3), otherwise on
  // the falling edge. The opposite edge shifts miso. Edges are only counted
  // while a selected transaction is in progress.
  assign xfer_active = en & ~ss_s & (state != S_IDLE);
  assign sample_edge = xfer_active & ((cpol == cpha) ? sclk_rise : sclk_fall);
  assign shift_edge  = xfer_active & ((cpol == cpha) ? sclk_fall : sclk_rise);

  assign rx_next   = lsbfirst ? {mosi_s, rx_sr[7:1]} : {rx_sr[6:0], mosi_s};
  assign byte_done = sample_edge & (bit_cnt == 3'd7);

  assign cmd_done = (state == S_CMD) & byte_done;
  assign rd_first = cmd_done & (rx_next[7:6] == 2'b10);
  assign wr_fire  = (state == S_WRITE) & byte_done;
  assign rd_next  = (state == S_READ) & byte_done;

  // Only read data is ever transmitted. The capture cycle is bypassed so a
  // byte that arrives in the same cycle as the load is not missed.
  assign tx_load    = (state == S_READ) ? (rd_capture ? spi_rdata : tx_hold) : 8'h00;
  assign tx_shifted = lsbfirst ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
  assign tx_bit     = lsbfirst ? tx_sr[0] : tx_sr[7];

  always_ff @(posedge clk) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  // NOTE: state_next gets its default before the case statement, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (ss_fall) state_next = S_CMD;
      S_CMD: begin
        if (byte_done) begin
          case (rx_next[7:6])
            2'b00:   state_next = S_WRITE;
            2'b10:   state_next = S_READ;
            default: state_next = S_IGNORE;
          endcase
        end
      end
      default: state_next = state;
    endcase
    // Deselect or disable aborts from any state; a partial byte is dropped.
    if (!en || ss_s) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      spi_write  <= 1'b0;
      spi_read   <= 1'b0;
      spi_addr   <= '0;
      spi_wdata  <= 8'h00;
      addr       <= '0;
      bit_cnt    <= 3'd0;
      rx_sr      <= 8'h00;
      tx_sr      <= 8'h00;
      tx_hold    <= 8'h00;
      prefetch   <= 1'b0;
      rd_capture <= 1'b0;
    end else begin
      spi_write <= 1'b0;
      spi_read  <= 1'b0;
      if (state_next == S_IDLE) begin
        bit_cnt    <= 3'd0;
        rx_sr      <= 8'h00;
        tx_sr      <= 8'h00;
        tx_hold    <= 8'h00;
        prefetch   <= 1'b0;
        rd_capture <= 1'b0;
      end else begin
        if (sample_edge) begin
          rx_sr   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
        end
        // bit_cnt==0 on a shift edge marks a byte boundary: the leading edge
        // of a new byte (cpha=1) or the trailing edge ending one (cpha=0).
        if (shift_edge) tx_sr <= (bit_cnt == 3'd0) ? tx_load : tx_shifted;

        if (cmd_done) addr <= rx_next[AW-1:0];
        if (rd_first) begin
          spi_read <= 1'b1;
          spi_addr <= rx_next[AW-1:0];
        end
        if (wr_fire) begin
          spi_write <= 1'b1;
          spi_addr  <= addr;
          spi_wdata <= rx_next;
          addr      <= addr + 1'b1;
        end
        if (rd_next) addr <= addr + 1'b1;
        // Prefetch issues one cycle after the increment, at the new address.
        if (prefetch) begin
          spi_read <= 1'b1;
          spi_addr <= addr;
        end
        prefetch   <= rd_next;
        rd_capture <= spi_read;
        if (rd_capture) tx_hold <= spi_rdata;
      end
    end
  end

  assign miso      = xfer_active & tx_bit;
  assign spi_state = state;

endmodule
